// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto envelope-generator voices,
// choosing retrigger, free, releasing or stolen voices and forcing a one-cycle gate gap on reuse.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned NOTE_BITS  = 7,
    parameter int unsigned AGE_BITS   = 8,
    localparam int unsigned VOICE_W   = $clog2(NUM_VOICES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_note_on,
    input  logic [NOTE_BITS-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]           env_active,
    output logic [NUM_VOICES-1:0]           gate,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
    output logic                            alloc_valid,
    output logic [VOICE_W-1:0]              alloc_voice,
    output logic                            stolen
);

    localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

    typedef enum logic {IDLE, GAP} state_t;

    state_t                            state_q, state_d;
    logic [AGE_BITS-1:0]               age_q [NUM_VOICES];
    logic [AGE_BITS-1:0]               age_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]             gate_d;
    logic [NUM_VOICES*NOTE_BITS-1:0]   note_d;
    logic [NOTE_BITS-1:0]              pend_note_q, pend_note_d;
    logic [VOICE_W-1:0]                pend_voice_q, pend_voice_d;
    logic                              pend_steal_q, pend_steal_d;
    logic                              alloc_valid_d, stolen_d;
    logic [VOICE_W-1:0]                alloc_voice_d;

    logic [NUM_VOICES-1:0]             match;
    logic                              hit_a, hit_b, hit_c, hit_d;
    logic [VOICE_W-1:0]                v_a, v_b, v_c, v_d;
    logic [AGE_BITS-1:0]               best_c, best_d;
    logic [VOICE_W-1:0]                victim;
    logic                              victim_gated, victim_steal;

    // Voices currently gated with the event's note
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            match[i] = gate[i] && (voice_note[i*NOTE_BITS +: NOTE_BITS] == ev_note);
        end
    end

    // Victim priority: retrigger, free, oldest releasing, oldest gated (ties to lowest index)
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        hit_c  = 1'b0;
        hit_d  = 1'b0;
        v_a    = '0;
        v_b    = '0;
        v_c    = '0;
        v_d    = '0;
        best_c = '0;
        best_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (match[i] && !hit_a) begin
                hit_a = 1'b1;
                v_a   = VOICE_W'(i);
            end
            if (!gate[i] && !env_active[i] && !hit_b) begin
                hit_b = 1'b1;
                v_b   = VOICE_W'(i);
            end
            if (!gate[i] && (!hit_c || age_q[i] > best_c)) begin
                hit_c  = 1'b1;
                v_c    = VOICE_W'(i);
                best_c = age_q[i];
            end
            if (gate[i] && (!hit_d || age_q[i] > best_d)) begin
                hit_d  = 1'b1;
                v_d    = VOICE_W'(i);
                best_d = age_q[i];
            end
        end
        victim       = v_d;
        victim_gated = 1'b1;
        victim_steal = 1'b1;
        if (hit_a) begin
            victim       = v_a;
            victim_steal = 1'b0;
        end else if (hit_b) begin
            victim       = v_b;
            victim_gated = 1'b0;
            victim_steal = 1'b0;
        end else if (hit_c) begin
            victim       = v_c;
            victim_gated = 1'b0;
            victim_steal = 1'b0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        gate_d        = gate;
        note_d        = voice_note;
        age_d         = age_q;
        pend_note_d   = pend_note_q;
        pend_voice_d  = pend_voice_q;
        pend_steal_d  = pend_steal_q;
        alloc_valid_d = 1'b0;
        alloc_voice_d = alloc_voice;
        stolen_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev_valid && ev_note_on) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (VOICE_W'(i) == victim) begin
                            age_d[i] = '0;
                        end else if (age_q[i] != AGE_MAX) begin
                            age_d[i] = age_q[i] + AGE_BITS'(1);
                        end
                    end
                    if (victim_gated) begin
                        gate_d[victim] = 1'b0;
                        pend_note_d    = ev_note;
                        pend_voice_d   = victim;
                        pend_steal_d   = victim_steal;
                        state_d        = GAP;
                    end else begin
                        gate_d[victim] = 1'b1;
                        note_d[int'(victim)*NOTE_BITS +: NOTE_BITS] = ev_note;
                        alloc_valid_d  = 1'b1;
                        alloc_voice_d  = victim;
                    end
                end else if (ev_valid) begin
                    gate_d = gate & ~match;
                end
            end
            GAP: begin
                gate_d[pend_voice_q] = 1'b1;
                note_d[int'(pend_voice_q)*NOTE_BITS +: NOTE_BITS] = pend_note_q;
                alloc_valid_d = 1'b1;
                alloc_voice_d = pend_voice_q;
                stolen_d      = pend_steal_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ev_ready     <= 1'b1;
            gate         <= '0;
            voice_note   <= '0;
            pend_note_q  <= '0;
            pend_voice_q <= '0;
            pend_steal_q <= 1'b0;
            alloc_valid  <= 1'b0;
            alloc_voice  <= '0;
            stolen       <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ev_ready     <= (state_d == IDLE);
            gate         <= gate_d;
            voice_note   <= note_d;
            pend_note_q  <= pend_note_d;
            pend_voice_q <= pend_voice_d;
            pend_steal_q <= pend_steal_d;
            alloc_valid  <= alloc_valid_d;
            alloc_voice  <= alloc_voice_d;
            stolen       <= stolen_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized and directed bench for voice_allocator against a behavioural voice-pool model.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NB = 7;
    localparam int AGE_MAX = 255;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ev_valid = 1'b0;
    logic            ev_ready;
    logic            ev_note_on = 1'b0;
    logic [NB-1:0]   ev_note = '0;
    logic [NV-1:0]   env_active = '0;
    logic [NV-1:0]   gate;
    logic [NV*NB-1:0] voice_note;
    logic            alloc_valid;
    logic [1:0]      alloc_voice;
    logic            stolen;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_BITS(NB), .AGE_BITS(8)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_note_on(ev_note_on), .ev_note(ev_note), .env_active(env_active),
        .gate(gate), .voice_note(voice_note), .alloc_valid(alloc_valid),
        .alloc_voice(alloc_voice), .stolen(stolen)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference voice pool
    int  m_gate [NV];
    int  m_note [NV];
    int  m_age  [NV];
    bit  m_gap, m_ps, m_alloc, m_stolen, m_known;
    int  m_pv, m_pn, m_av;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void pick(input int note, input logic [NV-1:0] env, output int v, output bit steal);
        int best;
        v = -1;
        steal = 1'b0;
        for (int i = 0; i < NV; i++)
            if (v < 0 && m_gate[i] == 1 && m_note[i] == note) v = i;
        for (int i = 0; i < NV; i++)
            if (v < 0 && m_gate[i] == 0 && env[i] == 1'b0) v = i;
        if (v < 0) begin
            best = -1;
            for (int i = 0; i < NV; i++)
                if (m_gate[i] == 0 && m_age[i] > best) begin best = m_age[i]; v = i; end
        end
        if (v < 0) begin
            best = -1;
            steal = 1'b1;
            for (int i = 0; i < NV; i++)
                if (m_gate[i] == 1 && m_age[i] > best) begin best = m_age[i]; v = i; end
        end
    endfunction

    function automatic void model_edge(input bit r, input bit v, input bit on, input int note,
                                       input logic [NV-1:0] env, output bit acc);
        int vi;
        bit st;
        acc = 1'b0;
        if (r) begin
            for (int k = 0; k < NV; k++) begin m_gate[k] = 0; m_note[k] = 0; m_age[k] = 0; end
            m_gap = 0; m_alloc = 0; m_stolen = 0; m_av = 0;
            return;
        end
        m_alloc = 0;
        m_stolen = 0;
        if (m_gap) begin
            m_gate[m_pv] = 1; m_note[m_pv] = m_pn;
            m_alloc = 1; m_av = m_pv; m_stolen = m_ps; m_gap = 0;
        end else if (v) begin
            acc = 1'b1;
            if (on) begin
                pick(note, env, vi, st);
                for (int k = 0; k < NV; k++)
                    m_age[k] = (k == vi) ? 0 : ((m_age[k] < AGE_MAX) ? m_age[k] + 1 : AGE_MAX);
                if (m_gate[vi] == 1) begin
                    m_gate[vi] = 0; m_pv = vi; m_pn = note; m_ps = st; m_gap = 1;
                end else begin
                    m_gate[vi] = 1; m_note[vi] = note; m_alloc = 1; m_av = vi;
                end
            end else begin
                for (int k = 0; k < NV; k++)
                    if (m_gate[k] == 1 && m_note[k] == note) m_gate[k] = 0;
            end
        end
    endfunction

    // One clock: drive on negedge, check ready before edge, update model, check outputs after edge
    task automatic cyc(input bit r, input bit v, input bit on, input int note,
                       input logic [NV-1:0] env, output bit acc);
        logic [NV-1:0]    eg;
        logic [NV*NB-1:0] en;
        @(negedge clk);
        rst = r; ev_valid = v; ev_note_on = on; ev_note = NB'(note); env_active = env;
        if (m_known) check("ev_ready", 64'(ev_ready), 64'(!m_gap));
        @(posedge clk);
        model_edge(r, v, on, note, env, acc);
        m_known = 1'b1;
        #1;
        for (int k = 0; k < NV; k++) begin
            eg[k] = m_gate[k][0];
            en[k*NB +: NB] = NB'(m_note[k]);
        end
        check("gate", 64'(gate), 64'(eg));
        check("voice_note", 64'(voice_note), 64'(en));
        check("alloc_valid", 64'(alloc_valid), 64'(m_alloc));
        check("stolen", 64'(stolen), 64'(m_stolen));
        if (m_alloc) check("alloc_voice", 64'(alloc_voice), 64'(m_av));
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, '0, a);
    endtask

    // Offer an event and hold it until accepted, within a small cycle budget
    task automatic send(input bit on, input int note, input logic [NV-1:0] env);
        bit a;
        a = 1'b0;
        for (int t = 0; t < 4 && !a; t++) cyc(1'b0, 1'b1, on, note, env, a);
        check("accept_timeout", 64'(a), 64'd1);
    endtask

    initial begin
        bit a;
        bit pend, p_on;
        int p_note;
        logic [NV*NB-1:0] tmp;
        m_known = 1'b0;

        // Basic fill and steal
        cyc(1'b1, 1'b0, 1'b0, 0, '0, a);
        cyc(1'b1, 1'b0, 1'b0, 0, '0, a);
        send(1'b1, 60, '0); send(1'b1, 62, '0); send(1'b1, 64, '0); send(1'b1, 65, '0);
        check("fill_gate", 64'(gate), 64'hF);
        check("fill_notes", 64'(voice_note), 64'({7'd65, 7'd64, 7'd62, 7'd60}));
        send(1'b1, 67, '0);
        check("steal_gap_gate", 64'(gate), 64'b1110);
        idle(1);
        check("steal_voice", 64'(alloc_voice), 64'd0);
        check("steal_flag", 64'(stolen), 64'd1);
        tmp = voice_note;
        check("steal_note", 64'(tmp[6:0]), 64'd67);

        // Release reuse and unmatched note-off
        send(1'b0, 62, 4'b1111);
        send(1'b1, 70, 4'b1111);
        check("release_voice", 64'(alloc_voice), 64'd1);
        check("release_nosteal", 64'(stolen), 64'd0);
        send(1'b0, 99, 4'b1111);
        check("noteoff_unused", 64'(gate), 64'hF);

        // Retrigger without steal
        send(1'b1, 64, 4'b1111);
        check("retrig_gap", 64'(gate), 64'b1011);
        idle(1);
        check("retrig_voice", 64'(alloc_voice), 64'd2);
        check("retrig_nosteal", 64'(stolen), 64'd0);

        // Reset during GAP, held event accepted afterwards
        send(1'b1, 80, '0);
        cyc(1'b1, 1'b1, 1'b1, 81, '0, a);
        check("rst_gap_gate", 64'(gate), 64'd0);
        send(1'b1, 81, '0);
        check("post_rst_voice", 64'(alloc_voice), 64'd0);

        // Age saturation on a never-chosen voice
        cyc(1'b1, 1'b0, 1'b0, 0, '0, a);
        send(1'b1, 10, '0); send(1'b1, 11, '0); send(1'b1, 12, '0); send(1'b1, 13, '0);
        for (int i = 0; i < 300; i++) send(1'b1, 10 + (i % 3), '0);
        idle(1);
        send(1'b1, 20, '0);
        idle(1);
        check("sat_voice", 64'(alloc_voice), 64'd3);
        check("sat_steal", 64'(stolen), 64'd1);

        // Randomized traffic with a source that holds unaccepted events
        pend = 1'b0; p_on = 1'b0; p_note = 0;
        for (int i = 0; i < 1500; i++) begin
            bit r;
            r = ($urandom_range(0, 79) == 0);
            if (!pend && $urandom_range(0, 9) < 6) begin
                pend = 1'b1;
                p_on = ($urandom_range(0, 2) != 0);
                p_note = 60 + $urandom_range(0, 5);
            end
            cyc(r, pend, p_on, p_note, NV'($urandom), a);
            if (a) pend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
